nfc_command_read_page_seq: RTL and testbench

Page-read command sequencer for the NAND flash controller (NFC). It sits between the command dispatcher and the atomic command generator (ACG). It issues 00h / address / 30h, waits for R/B#, and streams page data. Unlike the single-page generation, it reads N consecutive pages with automatic row-address increment, supports a configurable address-cycle count, and can abort on a busy timeout.

---
 rtl/nfc_command_read_page_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_nfc_command_read_page_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_command_read_page_seq.sv
// Multi-page NAND read sequencer: 00h / address / 30h, R/B# wait, data, with automatic row increment.
// Define NFC_READ_TIMEOUT_EN to enable the busy-wait abort counter (oTimeout); otherwise WAITHIGH waits forever.
module nfc_command_read_page_seq #(
  parameter int          NumberOfWays = 4,
  parameter logic [5:0]  CommandID    = 6'b000100,
  parameter logic [4:0]  TargetID     = 5'b00101,
  parameter int          AddrCycles   = 5,
  parameter logic [19:0] TimeoutLimit = 20'hFFFFF
) (
  input  logic                    iSystemClock,
  input  logic                    iResetN,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic [39:0]             iAddress,
  input  logic [15:0]             iLength,
  input  logic [7:0]              iPageCount,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  output logic                    oStart,
  output logic                    oLastStep,
  output logic                    oTimeout,
  output logic [7:0]              oACG_Command,
  output logic [2:0]              oACG_CommandOption,
  input  logic [7:0]              iACG_Ready,
  input  logic [7:0]              iACG_LastStep,
  output logic [NumberOfWays-1:0] oACG_TargetWay,
  output logic [15:0]             oACG_NumOfData,
  output logic                    oACG_CASelect,
  output logic [39:0]             oACG_CAData,
  input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

  typedef enum logic [3:0] {
    sIdle, sLatch, sCmd1, sAddr, sCmd2, sWaitLow, sWaitHigh, sData, sNext
  } stateT;

  localparam logic [23:0] RowMask = 24'((32'd1 << (8 * (AddrCycles - 2))) - 32'd1);

  stateT                   rState;
  logic [39:0]             rAddress;
  logic [15:0]             rLength;
  logic [7:0]              rPagesLeft;
  logic [3:0]              rWaitCnt;
  logic [NumberOfWays-1:0] rbSync_p0;
  logic [NumberOfWays-1:0] rbSync_p1;
`ifdef NFC_READ_TIMEOUT_EN
  logic [19:0]             rTimeCnt;
`endif

  logic wAcgReady;
  logic wRB;
  logic unusedInputs;

  assign wAcgReady          = (iACG_Ready[6:0] == 7'h7F);
  assign wRB                = |rbSync_p1;
  assign oStart             = iCMDValid & (iOpcode == CommandID) & (iTargetID == TargetID) & oCMDReady;
  assign oACG_CommandOption = 3'b000;
  assign unusedInputs       = ^{iSourceID, iACG_Ready[7], iACG_LastStep[7:4], iACG_LastStep[2],
                                iACG_LastStep[0]};

  // Row field occupies bytes 2..AddrCycles-1 and wraps silently; bytes above it are left alone.
  function automatic logic [39:0] nextRowAddress(input logic [39:0] addr);
    logic [23:0] row;
    row = addr[39:16];
    row = (row & ~RowMask) | ((row + 24'd1) & RowMask);
    return {row, 16'h0000};
  endfunction

  always_ff @(posedge iSystemClock) begin
    if (!iResetN) begin
      rState         <= sIdle;
      oCMDReady      <= 1'b1;
      oLastStep      <= 1'b0;
      oTimeout       <= 1'b0;
      oACG_Command   <= 8'h00;
      oACG_TargetWay <= '0;
      oACG_NumOfData <= 16'h0000;
      oACG_CASelect  <= 1'b1;
      oACG_CAData    <= 40'h0;
      rAddress       <= 40'h0;
      rLength        <= 16'h0000;
      rPagesLeft     <= 8'h00;
      rWaitCnt       <= 4'h0;
      rbSync_p0      <= '0;
      rbSync_p1      <= '0;
`ifdef NFC_READ_TIMEOUT_EN
      rTimeCnt       <= 20'h0;
`endif
    end else begin
      // R/B# stage p0: mask to the target ways; stage p1: second flop before the OR-reduce
      rbSync_p0 <= iACG_ReadyBusy & oACG_TargetWay;
      rbSync_p1 <= rbSync_p0;
      oLastStep <= 1'b0;

      case (rState)
        sIdle: begin
          oCMDReady <= 1'b1;
          // Capture on the accept edge so LATCH already holds the command and can issue CMD1.
          if (oStart) begin
            rAddress       <= iAddress;
            rLength        <= iLength;
            oACG_TargetWay <= iWaySelect;
            rPagesLeft     <= (iPageCount == 8'd0) ? 8'd1 : iPageCount;
            oCMDReady      <= 1'b0;
            rState         <= sLatch;
          end
        end

        sLatch: begin
          oTimeout       <= 1'b0;
          oACG_CASelect  <= 1'b1;
          oACG_CAData    <= {8'h00, 32'h0};
          oACG_NumOfData <= 16'h0000;
          if (wAcgReady) oACG_Command <= 8'h08;
          rState <= sCmd1;
        end

        sCmd1: begin
          oACG_CASelect  <= 1'b1;
          oACG_CAData    <= {8'h00, 32'h0};
          oACG_NumOfData <= 16'h0000;
          if (oACG_Command != 8'h00) begin
            if (iACG_LastStep[3]) begin
              oACG_Command <= 8'h00;
              rState       <= sAddr;
            end
          end else if (wAcgReady) begin
            oACG_Command <= 8'h08;
          end
        end

        sAddr: begin
          oACG_CASelect  <= 1'b0;
          oACG_CAData    <= rAddress;
          oACG_NumOfData <= 16'(AddrCycles);
          if (oACG_Command != 8'h00) begin
            if (iACG_LastStep[3]) begin
              oACG_Command <= 8'h00;
              rState       <= sCmd2;
            end
          end else if (wAcgReady) begin
            oACG_Command <= 8'h08;
          end
        end

        sCmd2: begin
          oACG_CASelect  <= 1'b1;
          oACG_CAData    <= {8'h30, 32'h0};
          oACG_NumOfData <= 16'h0000;
          if (oACG_Command != 8'h00) begin
            if (iACG_LastStep[3]) begin
              oACG_Command <= 8'h00;
              rWaitCnt     <= 4'h0;
              rState       <= sWaitLow;
            end
          end else if (wAcgReady) begin
            oACG_Command <= 8'h08;
          end
        end

        sWaitLow: begin
          // A device that never drops R/B# inside the tWB window is treated as already done.
          if (!wRB || (rWaitCnt == 4'd15)) begin
            rState <= sWaitHigh;
`ifdef NFC_READ_TIMEOUT_EN
            rTimeCnt <= 20'h0;
`endif
          end else begin
            rWaitCnt <= rWaitCnt + 4'd1;
          end
        end

        sWaitHigh: begin
          if (wRB) begin
            rState <= sData;
`ifdef NFC_READ_TIMEOUT_EN
          end else if (rTimeCnt == TimeoutLimit) begin
            oTimeout   <= 1'b1;
            oLastStep  <= 1'b1;
            oCMDReady  <= 1'b1;
            rPagesLeft <= 8'h00;
            rState     <= sIdle;
          end else begin
            rTimeCnt <= rTimeCnt + 20'd1;
`endif
          end
        end

        sData: begin
          oACG_CASelect  <= 1'b0;
          oACG_CAData    <= 40'h0;
          oACG_NumOfData <= rLength;
          if (oACG_Command != 8'h00) begin
            if (iACG_LastStep[1]) begin
              oACG_Command <= 8'h00;
              rState       <= sNext;
            end
          end else if (wAcgReady) begin
            oACG_Command <= 8'h02;
          end
        end

        sNext: begin
          rPagesLeft <= rPagesLeft - 8'd1;
          if (rPagesLeft != 8'd1) begin
            rAddress <= nextRowAddress(rAddress);
            rState   <= sCmd1;
          end else begin
            oLastStep <= 1'b1;
            oCMDReady <= 1'b1;
            rState    <= sIdle;
          end
        end

        default: rState <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_command_read_page_seq.sv
// Scoreboard bench for nfc_command_read_page_seq: expected ACG steps and completions are queued by stimulus,
// a monitor pops and compares them, and a simple ACG/NAND responder answers the DUT's commands.
module tb_nfc_command_read_page_seq;

  typedef struct packed {
    logic [7:0]  cmd;
    logic        casel;
    logic [39:0] data;
    logic [15:0] num;
    logic [3:0]  way;
    logic        chkData;
    logic        chkNum;
  } acgTxnT;

  logic        clk = 1'b0;
  logic        iResetN;
  logic [5:0]  iOpcode;
  logic [4:0]  iTargetID;
  logic [4:0]  iSourceID;
  logic [39:0] iAddress;
  logic [15:0] iLength;
  logic [7:0]  iPageCount;
  logic        iCMDValid;
  logic        oCMDReady;
  logic [3:0]  iWaySelect;
  logic        oStart;
  logic        oLastStep;
  logic        oTimeout;
  logic [7:0]  oACG_Command;
  logic [2:0]  oACG_CommandOption;
  logic [7:0]  iACG_Ready;
  logic [7:0]  iACG_LastStep;
  logic [3:0]  oACG_TargetWay;
  logic [15:0] oACG_NumOfData;
  logic        oACG_CASelect;
  logic [39:0] oACG_CAData;
  logic [3:0]  iACG_ReadyBusy;

  acgTxnT expQ[$];
  logic   lastQ[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     rbMode = 0;
  int     rbTimer = 0;
  bit     rbStuck = 0;
  int     cmd2Cyc = 0;
  bit     gapCheck = 0;
  bit     toGapCheck = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nfc_command_read_page_seq #(
    .NumberOfWays(4), .CommandID(6'b000100), .TargetID(5'b00101),
    .AddrCycles(5), .TimeoutLimit(20'd100)
  ) dut (
    .iSystemClock(clk), .iResetN(iResetN), .iOpcode(iOpcode), .iTargetID(iTargetID),
    .iSourceID(iSourceID), .iAddress(iAddress), .iLength(iLength), .iPageCount(iPageCount),
    .iCMDValid(iCMDValid), .oCMDReady(oCMDReady), .iWaySelect(iWaySelect), .oStart(oStart),
    .oLastStep(oLastStep), .oTimeout(oTimeout), .oACG_Command(oACG_Command),
    .oACG_CommandOption(oACG_CommandOption), .iACG_Ready(iACG_Ready),
    .iACG_LastStep(iACG_LastStep), .oACG_TargetWay(oACG_TargetWay),
    .oACG_NumOfData(oACG_NumOfData), .oACG_CASelect(oACG_CASelect), .oACG_CAData(oACG_CAData),
    .iACG_ReadyBusy(iACG_ReadyBusy)
  );

  // ACG and NAND responder: each step completes 3 cycles after it is issued; R/B# per rbMode.
  initial begin
    int rspCnt;
    bit rspDone;
    rspCnt = 0;
    rspDone = 0;
    iACG_LastStep = 8'h00;
    iACG_ReadyBusy = 4'hF;
    forever begin
      @(negedge clk);
      iACG_LastStep = 8'h00;
      if (oACG_Command == 8'h00) begin
        rspCnt = 0;
        rspDone = 0;
      end else if (!rspDone) begin
        rspCnt++;
        if (rspCnt == 3) begin
          iACG_LastStep = (oACG_Command == 8'h02) ? 8'h02 : 8'h08;
          rspDone = 1;
          if (oACG_Command == 8'h08 && oACG_CASelect && oACG_CAData[39:32] == 8'h30) begin
            cmd2Cyc = cyc;
            if (rbMode == 0) rbTimer = 9;
            else if (rbMode == 2) rbStuck = 1;
          end
        end
      end
      if (rbTimer > 0) rbTimer--;
      iACG_ReadyBusy = (rbStuck || (rbTimer >= 1 && rbTimer <= 6)) ? 4'h0 : 4'hF;
    end
  end

  // Monitor: compare every newly issued ACG step and every completion pulse against the queues.
  initial begin
    acgTxnT e;
    logic [7:0] prevCmd;
    logic expTo;
    int gap;
    prevCmd = 8'h00;
    forever begin
      @(negedge clk);
      if (iResetN && prevCmd == 8'h00 && oACG_Command != 8'h00) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL acg_unexpected cmd=%h casel=%b data=%h num=%0d (nothing expected)",
                   oACG_Command, oACG_CASelect, oACG_CAData, oACG_NumOfData);
        end else begin
          e = expQ.pop_front();
          if (oACG_Command !== e.cmd || oACG_CASelect !== e.casel || oACG_TargetWay !== e.way ||
              (e.chkData && oACG_CAData !== e.data) || (e.chkNum && oACG_NumOfData !== e.num)) begin
            failures++;
            $display("FAIL acg_step actual cmd=%h casel=%b data=%h num=%0d way=%b required cmd=%h casel=%b data=%h num=%0d way=%b",
                     oACG_Command, oACG_CASelect, oACG_CAData, oACG_NumOfData, oACG_TargetWay,
                     e.cmd, e.casel, e.data, e.num, e.way);
          end
        end
        if (gapCheck && oACG_Command == 8'h02) begin
          gap = cyc - cmd2Cyc;
          checks++;
          if (gap < 18 || gap > 20) begin
            failures++;
            $display("FAIL twb_window_gap actual=%0d required=18..20", gap);
          end
        end
      end
      prevCmd = oACG_Command;
      if (oLastStep) begin
        checks++;
        if (lastQ.size() == 0) begin
          failures++;
          $display("FAIL laststep_unexpected timeout=%b (no completion expected)", oTimeout);
        end else begin
          expTo = lastQ.pop_front();
          if (oTimeout !== expTo || oCMDReady !== 1'b1) begin
            failures++;
            $display("FAIL laststep actual timeout=%b ready=%b required timeout=%b ready=1",
                     oTimeout, oCMDReady, expTo);
          end
        end
        if (toGapCheck) begin
          gap = cyc - cmd2Cyc;
          checks++;
          if (gap < 95 || gap > 115) begin
            failures++;
            $display("FAIL timeout_gap actual=%0d required=95..115", gap);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, "_ctl"}, {oCMDReady, oLastStep, oTimeout, oACG_Command, oACG_CommandOption,
                           oACG_TargetWay, oACG_NumOfData, oACG_CASelect},
          {1'b1, 1'b0, 1'b0, 8'h00, 3'h0, 4'h0, 16'h0000, 1'b1});
    check({name, "_cadata"}, oACG_CAData, 40'h0);
  endtask

  task automatic pushPage(input logic [39:0] addr, input logic [15:0] len, input logic [3:0] way,
                          input bit withData);
    expQ.push_back('{8'h08, 1'b1, 40'h00_0000_0000, 16'h0, way, 1'b1, 1'b0});
    expQ.push_back('{8'h08, 1'b0, addr, 16'd5, way, 1'b1, 1'b1});
    expQ.push_back('{8'h08, 1'b1, 40'h30_0000_0000, 16'h0, way, 1'b1, 1'b0});
    if (withData) expQ.push_back('{8'h02, 1'b0, 40'h0, len, way, 1'b0, 1'b1});
  endtask

  // Returns at the falling edge after the accept edge.
  task automatic accept(input logic [39:0] addr, input logic [15:0] len, input logic [7:0] pages,
                        input logic [3:0] way);
    iOpcode = 6'b000100;
    iTargetID = 5'b00101;
    iSourceID = 5'h1A;
    iAddress = addr;
    iLength = len;
    iPageCount = pages;
    iWaySelect = way;
    iCMDValid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !oStart; i++) @(negedge clk);
    check("accept_start", oStart, 1'b1);
    @(negedge clk);
    check("start_ignored_busy", oStart, 1'b0);
    iCMDValid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget && (expQ.size() != 0 || lastQ.size() != 0); i++) @(negedge clk);
    checks++;
    if (expQ.size() != 0 || lastQ.size() != 0) begin
      failures++;
      $display("FAIL completion_timeout pending_steps=%0d pending_laststep=%0d required=0/0",
               expQ.size(), lastQ.size());
    end
    expQ.delete();
    lastQ.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nz;
    bit found;
    iResetN = 1'b0;
    iOpcode = 6'h00;
    iTargetID = 5'h00;
    iSourceID = 5'h00;
    iAddress = 40'h0;
    iLength = 16'h0;
    iPageCount = 8'h00;
    iCMDValid = 1'b0;
    iWaySelect = 4'h0;
    iACG_Ready = 8'hFF;
    repeat (3) @(negedge clk);

    // Reset state and the combinational accept equation
    checkResetOutputs("reset");
    check("start_no_valid", oStart, 1'b0);
    iCMDValid = 1'b1; iOpcode = 6'b000101; iTargetID = 5'b00101; #1;
    check("start_bad_opcode", oStart, 1'b0);
    iOpcode = 6'b000100; iTargetID = 5'b00100; #1;
    check("start_bad_target", oStart, 1'b0);
    iTargetID = 5'b00101; #1;
    check("start_match", oStart, 1'b1);
    iCMDValid = 1'b0;
    @(negedge clk);
    iResetN = 1'b1;
    @(negedge clk);

    // Single page, accept-to-CMD1 latency of 2 cycles
    pushPage(40'h01_2345_0000, 16'd2048, 4'b0010, 1);
    lastQ.push_back(1'b0);
    accept(40'h01_2345_0000, 16'd2048, 8'd1, 4'b0010);
    check("cmd1_latency_1", oACG_Command, 8'h00);
    @(negedge clk);
    check("cmd1_latency_2", oACG_Command, 8'h08);
    waitIdle(300);

    // Three pages across the row wrap; the first column is nonzero and must be cleared afterwards
    pushPage(40'hFF_FFFE_1234, 16'd512, 4'b0001, 1);
    pushPage(40'hFF_FFFF_0000, 16'd512, 4'b0001, 1);
    pushPage(40'h00_0000_0000, 16'd512, 4'b0001, 1);
    lastQ.push_back(1'b0);
    accept(40'hFF_FFFE_1234, 16'd512, 8'd3, 4'b0001);
    waitIdle(600);

    // R/B# never drops: the tWB window expires, then DATA follows; page count 0 acts as 1
    rbMode = 1;
    gapCheck = 1;
    pushPage(40'h00_0010_0040, 16'd8, 4'b0100, 1);
    lastQ.push_back(1'b0);
    accept(40'h00_0010_0040, 16'd8, 8'd0, 4'b0100);
    waitIdle(300);
    gapCheck = 0;
    rbMode = 0;

    // ACG not ready during CMD1: no command until Ready[6:0] returns to 7F
    iACG_Ready = 8'h3F;
    pushPage(40'h00_0020_0000, 16'd16, 4'b1000, 1);
    lastQ.push_back(1'b0);
    accept(40'h00_0020_0000, 16'd16, 8'd1, 4'b1000);
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (oACG_Command != 8'h00) nz++;
    end
    check("stall_hold_cycles", nz, 0);
    iACG_Ready = 8'hFF;
    @(negedge clk);
    check("stall_release", oACG_Command, 8'h08);
    waitIdle(300);

    // Reset pulse during DATA, then a normal command
    pushPage(40'h00_0030_0000, 16'd64, 4'b0010, 1);
    accept(40'h00_0030_0000, 16'd64, 8'd2, 4'b0010);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (oACG_Command == 8'h02) found = 1;
    end
    check("reach_data", found, 1'b1);
    iResetN = 1'b0;
    @(negedge clk);
    checkResetOutputs("mid_reset");
    iResetN = 1'b1;
    waitIdle(10);
    pushPage(40'h00_0040_0000, 16'd32, 4'b0001, 1);
    lastQ.push_back(1'b0);
    accept(40'h00_0040_0000, 16'd32, 8'd1, 4'b0001);
    waitIdle(300);

`ifdef NFC_READ_TIMEOUT_EN
    // R/B# stuck low: abort after the limit, skip the second page, sticky flag cleared by next accept
    rbMode = 2;
    toGapCheck = 1;
    pushPage(40'h00_0050_0000, 16'd32, 4'b0010, 0);
    lastQ.push_back(1'b1);
    accept(40'h00_0050_0000, 16'd32, 8'd2, 4'b0010);
    waitIdle(400);
    toGapCheck = 0;
    check("timeout_sticky", oTimeout, 1'b1);
    rbStuck = 0;
    rbMode = 0;
    pushPage(40'h00_0060_0000, 16'd32, 4'b0010, 1);
    lastQ.push_back(1'b0);
    accept(40'h00_0060_0000, 16'd32, 8'd1, 4'b0010);
    @(negedge clk);
    check("timeout_cleared", oTimeout, 1'b0);
    waitIdle(300);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
